hazard_scoreboard_unit: RTL

//  Next-generation pipeline hazard controller for the 5-stage core. Keeps the MEM/WB forwarding
//  and branch flush of the current hazard logic. Adds a per-register scoreboard for long-latency
//  (MUL/DIV) writebacks. Adds a multi-cycle load-use stall for slower data memory, an

---
 rtl/hazard_scoreboard_unit_if.sv | 57 +++++
 rtl/hazard_scoreboard_unit.sv | 123 ++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard_unit_if.sv
// Hazard-unit bundle: decode/EX/MEM/WB observation and long-op retire inputs, plus
// forwarding, stall/flush, scoreboard status and performance outputs.
interface hazard_scoreboard_unit_if #(
  parameter int REG_AW       = 5,
  parameter int MAX_LONG_OPS = 4,
  parameter int CNT_W        = 32
);
  localparam int LPW = $clog2(MAX_LONG_OPS + 1);

  logic              dec_valid;
  logic [REG_AW-1:0] dec_rs1_addr;
  logic [REG_AW-1:0] dec_rs2_addr;
  logic              dec_uses_rs1;
  logic              dec_uses_rs2;
  logic [REG_AW-1:0] dec_rd_addr;
  logic              dec_is_long;
  logic [REG_AW-1:0] ex_rs1_addr;
  logic [REG_AW-1:0] ex_rs2_addr;
  logic [REG_AW-1:0] ex_rd_addr;
  logic              ex_is_load;
  logic [REG_AW-1:0] mem_reg_write_addr;
  logic              mem_reg_write_signal;
  logic [REG_AW-1:0] wb_reg_write_addr;
  logic              wb_reg_write_signal;
  logic              long_done;
  logic [REG_AW-1:0] long_done_addr;
  logic              pc_select;
  logic [1:0]        forward_alu_a;
  logic [1:0]        forward_alu_b;
  logic              stall_pc;
  logic              stall_fetch_decode_pipeline;
  logic              flush_fetch_decode_pipeline;
  logic              flush_dec_ex_pipeline;
  logic [LPW-1:0]    long_pending;
  logic [CNT_W-1:0]  stall_cycle_count;
  logic              sb_error;

  modport master (
    output dec_valid, dec_rs1_addr, dec_rs2_addr, dec_uses_rs1, dec_uses_rs2,
           dec_rd_addr, dec_is_long, ex_rs1_addr, ex_rs2_addr, ex_rd_addr, ex_is_load,
           mem_reg_write_addr, mem_reg_write_signal, wb_reg_write_addr, wb_reg_write_signal,
           long_done, long_done_addr, pc_select,
    input  forward_alu_a, forward_alu_b, stall_pc, stall_fetch_decode_pipeline,
           flush_fetch_decode_pipeline, flush_dec_ex_pipeline, long_pending,
           stall_cycle_count, sb_error
  );

  modport slave (
    input  dec_valid, dec_rs1_addr, dec_rs2_addr, dec_uses_rs1, dec_uses_rs2,
           dec_rd_addr, dec_is_long, ex_rs1_addr, ex_rs2_addr, ex_rd_addr, ex_is_load,
           mem_reg_write_addr, mem_reg_write_signal, wb_reg_write_addr, wb_reg_write_signal,
           long_done, long_done_addr, pc_select,
    output forward_alu_a, forward_alu_b, stall_pc, stall_fetch_decode_pipeline,
           flush_fetch_decode_pipeline, flush_dec_ex_pipeline, long_pending,
           stall_cycle_count, sb_error
  );
endinterface

// File: rtl/hazard_scoreboard_unit.sv
// 5-stage pipeline hazard controller: MEM/WB forwarding, multi-cycle load-use stall,
// long-latency (MUL/DIV) register scoreboard, branch flush and saturating stall counter.
module hazard_scoreboard_unit #(
  parameter int REG_AW         = 5,
  parameter int LOAD_USE_STALL = 1,
  parameter int MAX_LONG_OPS   = 4,
  parameter int CNT_W          = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  hazard_scoreboard_unit_if.slave  bus
);
  localparam int NREGS = 2 ** REG_AW;
  localparam int LPW   = $clog2(MAX_LONG_OPS + 1);
  localparam int LUW   = $clog2(LOAD_USE_STALL + 1);
  localparam logic [LPW-1:0] PEND_FULL = LPW'(MAX_LONG_OPS);
  localparam logic [LUW-1:0] LU_RELOAD = LUW'(LOAD_USE_STALL - 1);

  function automatic logic [1:0] fwd_sel(
    input logic [REG_AW-1:0] src,
    input logic [REG_AW-1:0] mem_addr,
    input logic              mem_wr,
    input logic [REG_AW-1:0] wb_addr,
    input logic              wb_wr
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (mem_wr && (mem_addr == src) && (src != '0))
      sel = 2'b11;
    else if (wb_wr && (wb_addr == src) && (src != '0))
      sel = 2'b10;
    return sel;
  endfunction

  logic [NREGS-1:0] r_busy;
  logic [LPW-1:0]   r_long_pending;
  logic [LUW-1:0]   r_lu_cnt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             r_sb_error;

  logic [NREGS-1:0] w_busy_nxt;
  logic w_lu_hit, w_lu_stall, w_sb_stall, w_stall, w_stall_pc;
  logic w_full, w_issue, w_retire_ok, w_retire_bad;

  assign bus.forward_alu_a = fwd_sel(bus.ex_rs1_addr, bus.mem_reg_write_addr,
                                     bus.mem_reg_write_signal, bus.wb_reg_write_addr,
                                     bus.wb_reg_write_signal);
  assign bus.forward_alu_b = fwd_sel(bus.ex_rs2_addr, bus.mem_reg_write_addr,
                                     bus.mem_reg_write_signal, bus.wb_reg_write_addr,
                                     bus.wb_reg_write_signal);

  assign w_lu_hit = bus.ex_is_load && (bus.ex_rd_addr != '0) && bus.dec_valid &&
                    ((bus.dec_uses_rs1 && (bus.dec_rs1_addr == bus.ex_rd_addr)) ||
                     (bus.dec_uses_rs2 && (bus.dec_rs2_addr == bus.ex_rd_addr)));
  assign w_lu_stall = w_lu_hit || (r_lu_cnt != '0);

  // Busy bits are read registered only: a retire frees its consumer one cycle later.
  assign w_full     = (r_long_pending == PEND_FULL);
  assign w_sb_stall = bus.dec_valid &&
                      ((bus.dec_uses_rs1 && r_busy[bus.dec_rs1_addr]) ||
                       (bus.dec_uses_rs2 && r_busy[bus.dec_rs2_addr]) ||
                       (bus.dec_is_long && (r_busy[bus.dec_rd_addr] || w_full)));

  assign w_stall    = w_lu_stall || w_sb_stall;
  assign w_stall_pc = w_stall && !bus.pc_select;

  assign bus.stall_pc                    = w_stall_pc;
  assign bus.stall_fetch_decode_pipeline = w_stall_pc;
  assign bus.flush_fetch_decode_pipeline = bus.pc_select;
  assign bus.flush_dec_ex_pipeline       = w_stall || bus.pc_select;
  assign bus.long_pending                = r_long_pending;
  assign bus.stall_cycle_count           = r_stall_cnt;
  assign bus.sb_error                    = r_sb_error;

  assign w_issue      = bus.dec_valid && bus.dec_is_long && !w_stall && !bus.pc_select;
  assign w_retire_ok  = bus.long_done && (r_long_pending != '0) && r_busy[bus.long_done_addr];
  assign w_retire_bad = bus.long_done && !w_retire_ok;

  always_comb begin
    w_busy_nxt = r_busy;
    if (w_issue && (bus.dec_rd_addr != '0))
      w_busy_nxt[bus.dec_rd_addr] = 1'b1;
    if (w_retire_ok)
      w_busy_nxt[bus.long_done_addr] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy         <= '0;
      r_long_pending <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      if (w_issue && !w_retire_ok)
        r_long_pending <= r_long_pending + LPW'(1);
      else if (w_retire_ok && !w_issue)
        r_long_pending <= r_long_pending - LPW'(1);
    end
  end

  // A redirect kills the stalled consumer, so any remaining load-use bubbles are moot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_lu_cnt <= '0;
    else if (bus.pc_select)
      r_lu_cnt <= '0;
    else if (w_lu_hit)
      r_lu_cnt <= LU_RELOAD;
    else if (r_lu_cnt != '0)
      r_lu_cnt <= r_lu_cnt - LUW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_sb_error  <= 1'b0;
    end else begin
      if (w_stall_pc && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_retire_bad)
        r_sb_error <= 1'b1;
    end
  end
endmodule
